// File: rtl/dmem_responder.sv
// Data-side bus responder for riscv_cpu: byte-enabled word RAM plus an MMIO block
// with a TX byte FIFO, a compare-interrupt timer and status/control registers.
module dmem_responder #(
   parameter int unsigned RAM_WORDS  = 1024,
   parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic        dmem_we,
   input  logic [3:0]  dmem_be,
   output logic [31:0] dmem_rdata,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        timer_irq,
   output logic        bus_err
);
   localparam int unsigned AW         = $clog2(RAM_WORDS);
   localparam int unsigned PW         = $clog2(FIFO_DEPTH);
   localparam int unsigned CW         = PW + 1;
   localparam logic [31:0] RAM_BYTES  = 32'(4 * RAM_WORDS);
   localparam logic [31:0] MMIO_BYTES = 32'd32;

   localparam logic [2:0] OFF_TX     = 3'd0;
   localparam logic [2:0] OFF_STATUS = 3'd1;
   localparam logic [2:0] OFF_CNT    = 3'd2;
   localparam logic [2:0] OFF_CMP    = 3'd3;
   localparam logic [2:0] OFF_CTRL   = 3'd4;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++)
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   // Address decode; the low two address bits never matter.
   logic [31:0]   ram_off_c;
   logic [31:0]   mmio_off_c;
   logic          ram_hit_c;
   logic          mmio_hit_c;
   logic [AW-1:0] ram_idx_c;
   logic [2:0]    reg_off_c;

   assign ram_off_c  = dmem_addr - RAM_BASE;
   assign mmio_off_c = dmem_addr - MMIO_BASE;
   assign ram_hit_c  = (dmem_addr >= RAM_BASE) && (ram_off_c < RAM_BYTES);
   assign mmio_hit_c = (dmem_addr >= MMIO_BASE) && (mmio_off_c < MMIO_BYTES);
   assign ram_idx_c  = ram_off_c[AW+1:2];
   assign reg_off_c  = dmem_addr[4:2];

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] fifo_cnt;
   logic          ovf;
   logic          irq_pend;
   logic          tmr_en;
   logic [31:0]   tmr_cnt;
   logic [31:0]   tmr_cmp;

   logic wr_reg_c, wr_sts_c, push_c, pop_c, push_ok_c, irq_set_c;

   assign wr_reg_c  = dmem_we && mmio_hit_c;
   assign wr_sts_c  = wr_reg_c && (reg_off_c == OFF_STATUS) && dmem_be[0];
   assign push_c    = wr_reg_c && (reg_off_c == OFF_TX) && dmem_be[0];
   assign pop_c     = tx_valid && tx_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok_c = push_c && ((fifo_cnt < CW'(FIFO_DEPTH)) || pop_c);
   assign irq_set_c = tmr_en && (tmr_cnt == tmr_cmp);

   // RAM contents survive reset.
   logic [31:0] ram [RAM_WORDS];
   always_ff @(posedge clk) begin
      if (dmem_we && ram_hit_c) begin
         for (int i = 0; i < 4; i++)
            if (dmem_be[i]) ram[ram_idx_c][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
   end

   // TX FIFO storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push_ok_c) begin
            fifo_mem[wr_ptr] <= dmem_wdata[7:0];
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop_c) rd_ptr <= rd_ptr + PW'(1);
         if (push_ok_c && !pop_c)      fifo_cnt <= fifo_cnt + CW'(1);
         else if (pop_c && !push_ok_c) fifo_cnt <= fifo_cnt - CW'(1);
      end
   end

   assign tx_valid = (fifo_cnt != '0);
   assign tx_data  = fifo_mem[rd_ptr];

   // Status, timer and bus-error registers; a set always beats a W1C clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf      <= 1'b0;
         irq_pend <= 1'b0;
         tmr_en   <= 1'b0;
         tmr_cnt  <= '0;
         tmr_cmp  <= '1;
         bus_err  <= 1'b0;
      end else begin
         bus_err <= dmem_we && !ram_hit_c && !mmio_hit_c;
         if (push_c && !push_ok_c)         ovf <= 1'b1;
         else if (wr_sts_c && dmem_wdata[2]) ovf <= 1'b0;
         if (irq_set_c)                      irq_pend <= 1'b1;
         else if (wr_sts_c && dmem_wdata[3]) irq_pend <= 1'b0;
         if (wr_reg_c && (reg_off_c == OFF_CNT))
            tmr_cnt <= be_merge(tmr_cnt, dmem_wdata, dmem_be);
         else if (tmr_en)
            tmr_cnt <= tmr_cnt + 32'd1;
         if (wr_reg_c && (reg_off_c == OFF_CMP))
            tmr_cmp <= be_merge(tmr_cmp, dmem_wdata, dmem_be);
         if (wr_reg_c && (reg_off_c == OFF_CTRL) && dmem_be[0])
            tmr_en <= dmem_wdata[0];
      end
   end

   assign timer_irq = irq_pend;

   // Side-effect-free combinational read path.
   always_comb begin
      dmem_rdata = '0;
      if (ram_hit_c) begin
         dmem_rdata = ram[ram_idx_c];
      end else if (mmio_hit_c) begin
         case (reg_off_c)
            OFF_STATUS: dmem_rdata = {20'd0, 4'(fifo_cnt), 4'd0, irq_pend, ovf,
                                      (fifo_cnt == '0), (fifo_cnt == CW'(FIFO_DEPTH))};
            OFF_CNT:    dmem_rdata = tmr_cnt;
            OFF_CMP:    dmem_rdata = tmr_cmp;
            OFF_CTRL:   dmem_rdata = {31'd0, tmr_en};
            default:    dmem_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus random traffic,
// checked against a queue/array reference model.
module tb_dmem_responder;
   localparam logic [31:0] MMIO   = 32'h1000_0000;
   localparam logic [31:0] A_TX   = MMIO;
   localparam logic [31:0] A_ST   = MMIO + 32'd4;
   localparam logic [31:0] A_CNT  = MMIO + 32'd8;
   localparam logic [31:0] A_CMP  = MMIO + 32'd12;
   localparam logic [31:0] A_CTRL = MMIO + 32'd16;
   localparam logic [31:0] A_RSV  = MMIO + 32'd24;
   localparam int          DEPTH  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] dmem_addr = '0;
   logic [31:0] dmem_wdata = '0;
   logic        dmem_we = 1'b0;
   logic [3:0]  dmem_be = '0;
   logic        tx_ready = 1'b0;
   logic [31:0] dmem_rdata;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        timer_irq;
   logic        bus_err;

   always #5 clk = ~clk;

   dmem_responder dut (
      .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .timer_irq(timer_irq), .bus_err(bus_err)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] ram_m [int];
   logic [7:0]  tx_q [$];
   logic        m_ovf, m_irq, m_en, m_berr;
   logic [31:0] m_cnt, m_cmp;

   // Pending read expectations
   logic [31:0] rd_exp_q [$];
   string       rd_name_q [$];
   logic        rd_chk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic bit is_ram(input logic [31:0] a);
      return a < 32'h0000_1000;
   endfunction

   function automatic bit is_mmio(input logic [31:0] a);
      return (a >= MMIO) && (a < MMIO + 32'd32);
   endfunction

   task automatic model_reset();
      tx_q.delete();
      m_ovf = 1'b0; m_irq = 1'b0; m_en = 1'b0; m_berr = 1'b0;
      m_cnt = 32'd0; m_cmp = 32'hFFFF_FFFF;
   endtask

   // Expected read value; returns 0 when the RAM word is not yet known.
   function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
      int sz;
      sz = tx_q.size();
      v = 32'd0;
      if (is_ram(a)) begin
         if (!ram_m.exists(int'(a >> 2))) return 1'b0;
         v = ram_m[int'(a >> 2)];
      end else if (is_mmio(a)) begin
         case (a[4:2])
            3'd1: v = {20'd0, 4'(sz), 4'd0, m_irq, m_ovf, (sz == 0), (sz == DEPTH)};
            3'd2: v = m_cnt;
            3'd3: v = m_cmp;
            3'd4: v = {31'd0, m_en};
            default: v = 32'd0;
         endcase
      end
      return 1'b1;
   endfunction

   // Advance the model across one clock edge (the monitor has already popped).
   task automatic model_update(input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be);
      bit          set_irq, clr_irq, new_en;
      logic [31:0] cnt_n;
      set_irq = m_en && (m_cnt == m_cmp);
      clr_irq = 1'b0;
      new_en  = m_en;
      cnt_n   = m_en ? m_cnt + 32'd1 : m_cnt;
      m_berr  = we && !is_ram(a) && !is_mmio(a);
      if (we && is_ram(a)) begin
         if (ram_m.exists(int'(a >> 2))) ram_m[int'(a >> 2)] = merge(ram_m[int'(a >> 2)], wd, be);
         else if (be == 4'hF)           ram_m[int'(a >> 2)] = wd;
      end else if (we && is_mmio(a)) begin
         case (a[4:2])
            3'd0: if (be[0]) begin
                     if (tx_q.size() < DEPTH) tx_q.push_back(wd[7:0]);
                     else m_ovf = 1'b1;
                  end
            3'd1: if (be[0]) begin
                     if (wd[2]) m_ovf = 1'b0;
                     if (wd[3]) clr_irq = 1'b1;
                  end
            3'd2: cnt_n = merge(m_cnt, wd, be);
            3'd3: m_cmp = merge(m_cmp, wd, be);
            3'd4: if (be[0]) new_en = wd[0];
            default: ;
         endcase
      end
      m_cnt = cnt_n;
      m_en  = new_en;
      if (set_irq) m_irq = 1'b1;
      else if (clr_irq) m_irq = 1'b0;
   endtask

   // One bus cycle, entered and left just after a rising edge.
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic rdy, input string name);
      logic [31:0] v;
      bit          known;
      dmem_we = we; dmem_addr = a; dmem_wdata = wd; dmem_be = be; tx_ready = rdy;
      known = exp_read(a, v);
      if (known && name != "") begin
         rd_exp_q.push_back(v);
         rd_name_q.push_back(name);
         rd_chk = 1'b1;
      end
      @(negedge clk); #1;
      rd_chk = 1'b0;
      model_update(we, a, wd, be);
      @(posedge clk); #1;
   endtask

   task automatic rd(input logic [31:0] a, input logic rdy, input string name);
      step(1'b0, a, 32'd0, 4'h0, rdy, name);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic rdy, input string name);
      step(1'b1, a, wd, be, rdy, name);
   endtask

   // Monitor: compares everything the DUT presents against the model.
   always @(negedge clk) begin
      if (rd_chk) check(rd_name_q.pop_front(), dmem_rdata, rd_exp_q.pop_front());
      check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      if (tx_q.size() != 0 && tx_ready) check("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
      check("timer_irq", 32'(timer_irq), 32'(m_irq));
      check("bus_err", 32'(bus_err), 32'(m_berr));
      if (!rst_n) check("tx_data_rst", 32'(tx_data), 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      model_update(1'b0, 32'd0, 32'd0, 4'h0);
      @(posedge clk); #1;

      // Reset register values
      rd(A_ST, 1'b0, "status_rst");
      rd(A_CMP, 1'b0, "cmp_rst");
      rd(A_CTRL, 1'b0, "ctrl_rst");
      rd(A_CNT, 1'b0, "cnt_rst");

      // RAM byte enables and same-cycle old-data read
      wr(32'h40, 32'h1122_3344, 4'hF, 1'b0, "ram_first");
      wr(32'h40, 32'hAABB_CCDD, 4'h5, 1'b0, "ram_same_cycle_old");
      rd(32'h40, 1'b0, "ram_be_merge");
      rd(32'h43, 1'b0, "ram_unaligned");
      wr(32'h44, 32'hDEAD_BEEF, 4'hF, 1'b0, "");
      wr(32'h44, 32'h0, 4'h0, 1'b0, "ram_be_zero");
      rd(32'h44, 1'b0, "ram_be_zero_rd");

      // FIFO fill, overflow, drain, W1C
      for (int i = 1; i <= 9; i++) wr(A_TX, 32'(i), 4'h1, 1'b0, "");
      rd(A_ST, 1'b0, "status_full_ovf");
      rd(A_TX, 1'b0, "tx_data_reads0");
      for (int i = 0; i < 9; i++) rd(A_ST, 1'b1, "status_drain");
      wr(A_ST, 32'h4, 4'h1, 1'b0, "status_w1c_ovf");
      rd(A_ST, 1'b0, "status_ovf_clr");

      // Push while full with a same-cycle pop
      for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + 32'(i), 4'h1, 1'b0, "");
      wr(A_TX, 32'h55, 4'h1, 1'b1, "status_push_pop");
      rd(A_ST, 1'b0, "status_full_no_ovf");
      for (int i = 0; i < 9; i++) rd(A_ST, 1'b1, "status_drain2");

      // Timer compare
      wr(A_CTRL, 32'h0, 4'hF, 1'b0, "");
      wr(A_CNT, 32'h0, 4'hF, 1'b0, "");
      wr(A_CMP, 32'h5, 4'hF, 1'b0, "");
      wr(A_CTRL, 32'h1, 4'h1, 1'b0, "");
      n = 0;
      while (!m_irq && n < 20) begin rd(A_CNT, 1'b0, "timer_cnt"); n++; end
      check("timer_irq_rise", 32'(timer_irq), 32'd1);
      wr(A_ST, 32'h8, 4'h1, 1'b0, "status_irq_w1c");
      rd(A_ST, 1'b0, "status_irq_clr");
      wr(A_CTRL, 32'h0, 4'h1, 1'b0, "");
      wr(A_CNT, 32'd9, 4'hF, 1'b0, "");
      wr(A_CMP, 32'd10, 4'hF, 1'b0, "");
      wr(A_CTRL, 32'h1, 4'h1, 1'b0, "");
      n = 0;
      while (!(m_en && m_cnt == m_cmp) && n < 20) begin rd(A_CNT, 1'b0, "timer_cnt2"); n++; end
      wr(A_ST, 32'h8, 4'h1, 1'b0, "status_set_vs_clr");
      check("irq_set_wins", 32'(timer_irq), 32'd1);

      // Unmapped and reserved accesses
      wr(32'h2000_0000, 32'h1234_5678, 4'hF, 1'b0, "unmapped_wr_rd");
      rd(32'h2000_0000, 1'b0, "unmapped_rd");
      wr(A_RSV, 32'hFFFF_FFFF, 4'hF, 1'b0, "reserved_wr_rd");
      rd(A_RSV, 1'b0, "reserved_rd");
      wr(MMIO + 32'd32, 32'h1, 4'hF, 1'b0, "mmio_end");
      wr(32'h0000_1000, 32'h1, 4'hF, 1'b0, "ram_end");
      rd(A_ST, 1'b0, "status_idle");

      // Asynchronous reset with traffic in flight
      for (int i = 0; i < 3; i++) wr(A_TX, 32'hA0 + 32'(i), 4'h1, 1'b0, "");
      dmem_we = 1'b0; dmem_addr = A_CNT; tx_ready = 1'b1;
      rst_n = 1'b0;
      model_reset();
      rd_exp_q.push_back(32'd0); rd_name_q.push_back("cnt_async_rst"); rd_chk = 1'b1;
      #1 check("tx_valid_async_rst", 32'(tx_valid), 32'd0);
      check("timer_irq_async_rst", 32'(timer_irq), 32'd0);
      @(negedge clk); #1;
      rd_chk = 1'b0;
      rst_n = 1'b1;
      model_update(1'b0, A_CNT, 32'd0, 4'h0);
      @(posedge clk); #1;
      rd(32'h40, 1'b0, "ram_after_rst");
      rd(A_CMP, 1'b0, "cmp_after_rst");
      rd(A_ST, 1'b0, "status_after_rst");

      // Random traffic
      for (int k = 0; k < 16; k++) wr(32'h100 + 32'(4*k), $urandom, 4'hF, 1'b0, "rnd_prefill");
      for (int it = 0; it < 400; it++) begin
         logic [31:0] a, d;
         logic [3:0]  be;
         logic        rdy;
         d   = $urandom;
         be  = 4'($urandom_range(0, 15));
         rdy = 1'($urandom_range(0, 1));
         a   = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0, 1, 2: wr(a, d, be, rdy, "rnd_ram_wr");
            3, 4:    rd(a, rdy, "rnd_ram_rd");
            5, 6:    wr(A_TX, d, be, rdy, "rnd_push");
            7:       if (rdy) wr(A_ST, d, be, rdy, "rnd_status_wr");
                     else     rd(A_ST, rdy, "rnd_status_rd");
            8:       if (be[1]) wr(32'($urandom_range(32'h1000, 32'h0FFF_FFFF)), d, be, rdy, "rnd_unmapped");
                     else       wr(A_RSV + 32'(4 * $urandom_range(0, 1)), d, be, rdy, "rnd_reserved");
            default: case ($urandom_range(0, 3))
                        0: wr(A_CNT, 32'($urandom_range(0, 40)), 4'hF, rdy, "rnd_cnt_wr");
                        1: wr(A_CMP, 32'($urandom_range(0, 40)), 4'hF, rdy, "rnd_cmp_wr");
                        2: wr(A_CTRL, d, be, rdy, "rnd_ctrl_wr");
                        default: rd(A_CNT, rdy, "rnd_cnt_rd");
                     endcase
         endcase
      end
      rd(A_ST, 1'b0, "status_final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
